// File: rtl/score_pkg.sv
// Shared types and segment tables for the score/best display block.
package score_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;
    typedef enum logic {SEL_SCORE, SEL_BEST} conv_sel_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [7:0] clamp_value(input logic [7:0] v, input logic [7:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/score_display_seg7.sv
// Single-digit decimal to active-low 7-segment decoder; non-decimal codes blank.
module seg7
    import score_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            seg = SEG_DIGIT[digit];
        end
    end

endmodule

// File: rtl/score_display.sv
// Live score and best score on four 7-segment displays, sharing one
// sequential divide-by-ten converter; the best pair blinks after a new record.
module score_display
    import score_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000,
    parameter int MAX_SCORE = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       on,
    input  logic [7:0] score,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       new_best
);

    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [7:0] MAX_V = 8'(MAX_SCORE);

    logic [7:0]  score_c;
    logic [7:0]  score_q;
    logic        on_q;
    logic [7:0]  best;
    logic        end_evt;
    logic        start_evt;

    conv_state_t state;
    conv_sel_t   sel;
    logic [7:0]  src;
    logic [7:0]  lat;
    logic [3:0]  tens;
    logic [7:0]  score_done;
    logic [7:0]  best_done;
    logic [3:0]  score_t, score_o, best_t, best_o;

    logic [CW-1:0] blink_cnt;
    logic          phase;
    logic          blank;
    logic [6:0]    seg2, seg3;

    assign score_c   = clamp_value(score, MAX_V);
    assign end_evt   = on_q & ~on;
    assign start_evt = ~on_q & on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q  <= '0;
            on_q     <= 1'b0;
            best     <= '0;
            new_best <= 1'b0;
        end else begin
            on_q <= on;
            if (on) begin
                score_q <= score_c;
            end
            if (end_evt && (score_q > best)) begin
                best     <= score_q;
                new_best <= 1'b1;
            end else if (start_evt) begin
                new_best <= 1'b0;
            end
        end
    end

    // Repeated subtraction: tens count ends in tens, remainder in src
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= SEL_SCORE;
            src        <= '0;
            lat        <= '0;
            tens       <= '0;
            score_done <= '0;
            best_done  <= '0;
            score_t    <= '0;
            score_o    <= '0;
            best_t     <= '0;
            best_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (score_q != score_done) begin
                        src   <= score_q;
                        lat   <= score_q;
                        sel   <= SEL_SCORE;
                        tens  <= '0;
                        state <= CONV;
                    end else if (best != best_done) begin
                        src   <= best;
                        lat   <= best;
                        sel   <= SEL_BEST;
                        tens  <= '0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    if (src >= 8'd10) begin
                        src  <= src - 8'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (sel == SEL_SCORE) begin
                        score_t    <= tens;
                        score_o    <= src[3:0];
                        score_done <= lat;
                    end else begin
                        best_t    <= tens;
                        best_o    <= src[3:0];
                        best_done <= lat;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (new_best) begin
            if (blink_cnt == CW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end
    end

    assign blank = new_best & ~phase;

    seg7 u_seg0 (.digit(score_o), .seg(hex0));
    seg7 u_seg1 (.digit(score_t), .seg(hex1));
    seg7 u_seg2 (.digit(best_o),  .seg(seg2));
    seg7 u_seg3 (.digit(best_t),  .seg(seg3));

    assign hex2 = blank ? SEG_BLANK : seg2;
    assign hex3 = blank ? SEG_BLANK : seg3;

endmodule

// File: tb/tb_score_display.sv
// Randomized bench for score_display with a value/timing-level reference model.
module tb_score_display;

    localparam int BLINK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       on;
    logic [7:0] score;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic       new_best;

    int checks = 0;
    int failures = 0;

    score_display #(.BLINK_DIV(BLINK_DIV), .MAX_SCORE(99)) dut (
        .clk(clk), .reset(reset), .on(on), .score(score),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .new_best(new_best)
    );

    always #5 clk = ~clk;

    function automatic int seg_of(input int d);
        case (d)
            0: return 'h40;
            1: return 'h79;
            2: return 'h24;
            3: return 'h30;
            4: return 'h19;
            5: return 'h12;
            6: return 'h02;
            7: return 'h78;
            8: return 'h00;
            9: return 'h10;
            default: return 'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: tracks what value each display pair shows and when
    int m_score_q, m_on_q, m_best, m_new_best;
    int m_disp_s, m_disp_b, m_sdone, m_bdone;
    int m_left, m_pend, m_pend_best;
    int m_cnt, m_phase;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_score_q = 0; m_on_q = 0; m_best = 0; m_new_best = 0;
            m_disp_s = 0; m_disp_b = 0; m_sdone = 0; m_bdone = 0;
            m_left = 0; m_pend = 0; m_pend_best = 0;
            m_cnt = 0; m_phase = 1;
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_pend_best != 0) begin
                        m_disp_b = m_pend; m_bdone = m_pend;
                    end else begin
                        m_disp_s = m_pend; m_sdone = m_pend;
                    end
                end
            end else if (m_score_q != m_sdone) begin
                m_pend = m_score_q; m_pend_best = 0; m_left = m_score_q / 10 + 2;
            end else if (m_best != m_bdone) begin
                m_pend = m_best; m_pend_best = 1; m_left = m_best / 10 + 2;
            end
            if (m_new_best != 0) begin
                if (m_cnt == BLINK_DIV - 1) begin
                    m_cnt = 0; m_phase = (m_phase != 0) ? 0 : 1;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_cnt = 0; m_phase = 1;
            end
            if (m_on_q != 0 && !on && m_score_q > m_best) begin
                m_best = m_score_q; m_new_best = 1;
            end
            if (m_on_q == 0 && on) m_new_best = 0;
            if (on) m_score_q = (int'(score) > 99) ? 99 : int'(score);
            m_on_q = on ? 1 : 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            int blank;
            blank = (m_new_best != 0 && m_phase == 0) ? 1 : 0;
            chk("hex0", int'(hex0), seg_of(m_disp_s % 10));
            chk("hex1", int'(hex1), seg_of(m_disp_s / 10));
            chk("hex2", int'(hex2), blank != 0 ? 'h7F : seg_of(m_disp_b % 10));
            chk("hex3", int'(hex3), blank != 0 ? 'h7F : seg_of(m_disp_b / 10));
            chk("new_best", int'(new_best), m_new_best);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int saw_blank;
        int k;
        reset = 1'b1; on = 1'b0; score = 8'd0;
        wait_cyc(3);
        chk("rst_hex0", int'(hex0), 'h40);
        chk("rst_hex3", int'(hex3), 'h40);
        chk("rst_new_best", int'(new_best), 0);
        reset = 1'b0;
        wait_cyc(2);

        // reset in the middle of converting 99
        on = 1'b1; score = 8'd99;
        wait_cyc(7);
        reset = 1'b1;
        #1;
        chk("midrst_hex0", int'(hex0), 'h40);
        chk("midrst_hex1", int'(hex1), 'h40);
        chk("midrst_hex2", int'(hex2), 'h40);
        chk("midrst_hex3", int'(hex3), 'h40);
        chk("midrst_new_best", int'(new_best), 0);
        wait_cyc(2);
        reset = 1'b0;

        score = 8'd0;
        wait_cyc(15);
        score = 8'd37;
        wait_cyc(12);
        chk("live_hex1", int'(hex1), 'h30);
        chk("live_hex0", int'(hex0), 'h78);
        chk("live_hex3", int'(hex3), 'h40);

        // new record at 42
        score = 8'd42;
        wait_cyc(12);
        on = 1'b0;
        wait_cyc(1);
        chk("rec_new_best", int'(new_best), 1);
        k = 0;
        while (k < 20 && !(hex3 == 7'h19 && hex2 == 7'h24)) begin
            @(negedge clk);
            k++;
        end
        chk("rec_digits_shown", (hex3 == 7'h19 && hex2 == 7'h24) ? 1 : 0, 1);
        saw_blank = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (hex3 == 7'h7F && hex2 == 7'h7F) saw_blank = 1;
        end
        chk("rec_blinks", saw_blank, 1);
        on = 1'b1; score = 8'd0;
        wait_cyc(1);
        chk("start_clears_new_best", int'(new_best), 0);
        chk("start_best_steady", int'(hex3), 'h19);
        wait_cyc(15);

        // non-record game ending at 30
        score = 8'd30;
        wait_cyc(12);
        on = 1'b0;
        wait_cyc(12);
        chk("nonrec_new_best", int'(new_best), 0);
        chk("nonrec_hex3", int'(hex3), 'h19);
        chk("nonrec_hex2", int'(hex2), 'h24);
        on = 1'b1; score = 8'd0;
        wait_cyc(12);
        chk("back_to_zero_hex1", int'(hex1), 'h40);
        chk("back_to_zero_hex0", int'(hex0), 'h40);

        score = 8'd150;
        wait_cyc(16);
        chk("clamp_hex1", int'(hex1), 'h10);
        chk("clamp_hex0", int'(hex0), 'h10);

        score = 8'd9;  wait_cyc(8);
        score = 8'd10; wait_cyc(8);
        score = 8'd11; wait_cyc(12);
        chk("b2b_hex1", int'(hex1), 'h79);
        chk("b2b_hex0", int'(hex0), 'h79);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) on = ~on;
            score = 8'($urandom_range(0, 160));
            wait_cyc($urandom_range(1, 12));
        end
        on = 1'b0;
        wait_cyc(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
